// File: rtl/sm_controller.sv
// Instruction-sequencing Moore FSM for the simple datapath.
// Walks each accepted instruction through its load/write cycles.
module sm_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       err
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_CMP_S,
    S_WR_REG
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] ins_q, ins_d;
  logic       err_q, err_d;

  logic is_movi;
  logic is_movr;
  logic is_mvn;
  logic is_alu;
  logic is_cmp;
  logic accept;

  // Instruction class decode from the captured instruction fields.
  always_comb begin
    is_movi = (ins_q == 5'b110_10);
    is_movr = (ins_q == 5'b110_00);
    is_mvn  = (ins_q == 5'b101_11);
    is_alu  = (ins_q[4:2] == 3'b101) && (ins_q[1:0] != 2'b11);
    is_cmp  = (ins_q == 5'b101_01);
    accept  = (state_q == S_WAIT) && s;
  end

  // State, captured instruction and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ins_q   <= 5'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
    end
  end

  // Next state, instruction capture and error flag update.
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          ins_d   = {opcode, op};
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_movi:          state_d = S_WR_IMM;
          is_movr | is_mvn: state_d = S_GET_B;
          is_alu:           state_d = S_GET_A;
          default: begin
            state_d = S_WAIT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = is_cmp ? S_CMP_S : S_EXEC;
      S_EXEC:   state_d = S_WR_REG;
      S_CMP_S:  state_d = S_WAIT;
      S_WR_REG: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    vsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    err   = err_q;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_WR_IMM: begin
        nsel  = 3'b100;
        vsel  = 2'b10;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        asel  = is_movr;
      end
      S_CMP_S: loads = 1'b1;
      S_WR_REG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_controller.sv
// Bench for sm_controller: per-instruction output schedule model,
// directed literal checks and a randomized instruction stream.
module tb_sm_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s = 1'b0;
  logic [2:0] opcode = 3'b0;
  logic [1:0] op = 2'b0;
  logic       w, loada, loadb, loadc, loads;
  logic       asel, bsel, write, err;
  logic [2:0] nsel;
  logic [1:0] vsel;

  int checks = 0;
  int errors = 0;

  sm_controller dut (
    .clk(clk), .reset_n(reset_n), .s(s),
    .opcode(opcode), .op(op), .w(w),
    .nsel(nsel), .vsel(vsel),
    .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel),
    .write(write), .err(err)
  );

  always #5 clk = ~clk;

  // {w, nsel, vsel, la, lb, lc, ls, asel, bsel, write}
  localparam logic [12:0] V_IDLE = {1'b1, 3'b000, 2'b00, 7'b0000000};
  localparam logic [12:0] V_DEC  = {1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [12:0] V_WRI  = {1'b0, 3'b100, 2'b10, 7'b0000001};
  localparam logic [12:0] V_GETA = {1'b0, 3'b100, 2'b00, 7'b1000000};
  localparam logic [12:0] V_GETB = {1'b0, 3'b001, 2'b00, 7'b0100000};
  localparam logic [12:0] V_EXA1 = {1'b0, 3'b000, 2'b00, 7'b0010100};
  localparam logic [12:0] V_EXA0 = {1'b0, 3'b000, 2'b00, 7'b0010000};
  localparam logic [12:0] V_CMPS = {1'b0, 3'b000, 2'b00, 7'b0001000};
  localparam logic [12:0] V_WRR  = {1'b0, 3'b010, 2'b00, 7'b0000001};

  logic [12:0] q[$];
  logic        err_m = 1'b0;
  logic        pend_err = 1'b0;

  // Queue the cycle-by-cycle outputs an instruction must produce.
  task automatic push_instr(input logic [2:0] oc, input logic [1:0] o);
    q.push_back(V_DEC);
    if (oc == 3'b110 && o == 2'b10) begin
      q.push_back(V_WRI);
    end else if (oc == 3'b110 && o == 2'b00) begin
      q.push_back(V_GETB); q.push_back(V_EXA1); q.push_back(V_WRR);
    end else if (oc == 3'b101 && o == 2'b11) begin
      q.push_back(V_GETB); q.push_back(V_EXA0); q.push_back(V_WRR);
    end else if (oc == 3'b101 && o == 2'b01) begin
      q.push_back(V_GETA); q.push_back(V_GETB); q.push_back(V_CMPS);
    end else if (oc == 3'b101) begin
      q.push_back(V_GETA); q.push_back(V_GETB);
      q.push_back(V_EXA0); q.push_back(V_WRR);
    end else begin
      pend_err = 1'b1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      err_m = 1'b0;
      pend_err = 1'b0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0 && pend_err) begin
        err_m = 1'b1;
        pend_err = 1'b0;
      end
    end else if (s) begin
      err_m = 1'b0;
      push_instr(opcode, op);
    end
  end

  logic [12:0] dut_v;
  logic [12:0] exp_v;
  assign dut_v = {w, nsel, vsel, loada, loadb, loadc,
                  loads, asel, bsel, write};

  always @(negedge clk) begin
    exp_v = (q.size() > 0) ? q[0] : V_IDLE;
    checks++;
    if (dut_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0t got %b want %b",
               $time, dut_v, exp_v);
    end
    checks++;
    if (err !== err_m) begin
      errors++;
      $display("FAIL err t=%0t got %b want %b", $time, err, err_m);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_instr(input logic [2:0] oc, input logic [1:0] o,
                          output int busy, output int wr,
                          output int ls_at, output int la_n,
                          output int as_n, output int err_dec);
    @(negedge clk);
    opcode = oc; op = o; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    busy = 0; wr = 0; ls_at = 0; la_n = 0; as_n = 0;
    err_dec = int'(err);
    while (w == 1'b0 && busy < 20) begin
      busy++;
      wr += int'(write);
      la_n += int'(loada);
      as_n += int'(asel & loadc);
      if (loads) ls_at = busy;
      @(negedge clk);
    end
  endtask

  int busy, wr, ls_at, la_n, as_n, err_dec;
  int waits, wrs, idx;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_w", int'(w), 1);
    chk("reset_write", int'(write), 0);
    chk("reset_err", int'(err), 0);
    reset_n = 1'b1;

    do_instr(3'b110, 2'b10, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("movi_busy", busy, 2);
    chk("movi_writes", wr, 1);

    do_instr(3'b101, 2'b00, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("add_busy", busy, 5);
    chk("add_writes", wr, 1);
    chk("add_loada", la_n, 1);

    do_instr(3'b101, 2'b01, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("cmp_busy", busy, 4);
    chk("cmp_loads_cycle", ls_at, 4);
    chk("cmp_writes", wr, 0);

    do_instr(3'b110, 2'b00, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("movr_busy", busy, 4);
    chk("movr_loada", la_n, 0);
    chk("movr_asel_exec", as_n, 1);

    do_instr(3'b111, 2'b00, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("ill_busy", busy, 1);
    chk("ill_writes", wr, 0);
    chk("ill_err", int'(err), 1);
    @(negedge clk);
    chk("ill_err_sticky", int'(err), 1);

    do_instr(3'b101, 2'b10, busy, wr, ls_at, la_n, as_n, err_dec);
    chk("err_clear", err_dec, 0);
    chk("and_busy", busy, 5);

    // Asynchronous reset while in GET_B of an ADD.
    @(negedge clk);
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_add_loadb", int'(loadb), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_w", int'(w), 1);
    chk("async_loadb", int'(loadb), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wrs = 0;
    repeat (8) begin
      @(negedge clk);
      wrs += int'(write);
    end
    chk("post_reset_writes", wrs, 0);

    // Back-to-back MVN with s held high.
    @(negedge clk);
    opcode = 3'b101; op = 2'b11; s = 1'b1;
    waits = 0; wrs = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 6) s = 1'b0;
      waits += int'(w);
      wrs += int'(write);
    end
    chk("b2b_waits", waits, 1);
    chk("b2b_writes", wrs, 2);
    @(negedge clk);
    chk("b2b_end_w", int'(w), 1);

    // Random instruction stream.
    repeat (600) begin
      @(negedge clk);
      if (q.size() == 0) begin
        idx = int'($urandom_range(0, 7));
        case (idx)
          0: {opcode, op} = 5'b110_10;
          1: {opcode, op} = 5'b110_00;
          2: {opcode, op} = 5'b101_11;
          3: {opcode, op} = 5'b101_00;
          4: {opcode, op} = 5'b101_01;
          5: {opcode, op} = 5'b101_10;
          default: {opcode, op} = 5'($urandom);
        endcase
      end
      s = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rand_async_w", int'(w), 1);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    s = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_controller.md
SM_CONTROLLER -- requirements
Module: sm_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 s  input  1  start request from the instruction-register stage.
REQ-005 opcode  input  3  instruction bits [15:13].
REQ-006 op  input  2  instruction bits [12:11].
REQ-007 w  output  1  waiting/idle indication; 1 only in WAIT.
REQ-008 nsel  output  3  one-hot register select to the decoder: 100=Rn, 010=Rd, 001=Rm, 000=none.
REQ-009 vsel  output  2  datapath writeback source select: 00=C register, 01=PC, 10=sximm8, 11=mdata.
REQ-010 loada, loadb, loadc, loads  output  1 each  datapath A, B, C and status register load enables.
REQ-011 asel, bsel  output  1 each  datapath ALU operand selects: asel=1 gives A operand 0; bsel=1 gives sximm5.
REQ-012 write  output  1  register-file write enable.
REQ-013 err  output  1  sticky unsupported-instruction flag.

Function
REQ-014 The block SHALL be a Moore FSM with states WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, CMP_S, WR_REG; outputs SHALL be a combinational function of the state, plus the latched err flag.
REQ-015 All outputs SHALL be 0 in any state except where this section sets them; w SHALL be 1 in WAIT only.
REQ-016 WAIT: if s=1 at a rising edge, the next state SHALL be DECODE; otherwise the FSM SHALL remain in WAIT.
REQ-017 DECODE: no enables are asserted. The next state SHALL be:
- WR_IMM for opcode=110, op=10 (MOV Rn,#im8).
- GET_B for opcode=110, op=00 (MOV Rd,Rm) and opcode=101, op=11 (MVN).
- GET_A for opcode=101, op=00/01/10 (ADD/CMP/AND).
- WAIT for any other code, with err set.
REQ-018 WR_IMM: nsel=100, vsel=10, write=1; next state WAIT.
REQ-019 GET_A: nsel=100, loada=1; next state GET_B.
REQ-020 GET_B: nsel=001, loadb=1; next state CMP_S if opcode=101 and op=01, otherwise EXEC.
REQ-021 EXEC: loadc=1, bsel=0; asel=1 only for MOV Rd,Rm, otherwise 0; next state WR_REG.
REQ-022 CMP_S: asel=0, bsel=0, loads=1; next state WAIT.
REQ-023 WR_REG: nsel=010, vsel=00, write=1; next state WAIT.
REQ-024 Latency from the edge that samples s=1 to re-entry of WAIT SHALL be:
- MOV imm: 2 cycles.
- MOV reg / MVN: 4 cycles.
- CMP: 4 cycles.
- ADD / AND: 5 cycles.
REQ-025 opcode and op SHALL be held stable by upstream logic while w=0; s SHALL be ignored while w=0.
REQ-026 If s is still 1 when the FSM re-enters WAIT, the next instruction SHALL start after exactly one WAIT cycle (back-to-back operation).
REQ-027 err SHALL set on the edge leaving DECODE for an unsupported code and SHALL clear on the next edge that accepts s=1 in WAIT.
REQ-028 write, loada, loadb, loadc and loads SHALL each be asserted for exactly one cycle per instruction that uses them, and never two of write/loadc in the same cycle.

Reset
REQ-029 reset_n=0 SHALL force state WAIT and err=0 immediately, independent of clk.
REQ-030 During reset, outputs SHALL be w=1 and all other outputs 0.
REQ-031 Reset mid-instruction SHALL abandon the instruction; no write SHALL occur after reset_n deasserts.
REQ-032 After reset_n deasserts, the first s=1 sampled SHALL be accepted at the next rising edge.

Verification
REQ-033 MOV imm: opcode=110, op=10, s pulsed 1 cycle -> DECODE, then WR_IMM with nsel=100, vsel=10, write=1 for one cycle; w=1 on the 3rd edge.
REQ-034 ADD: opcode=101, op=00 -> loada (nsel=100), then loadb (nsel=001), then loadc (asel=0), then write (nsel=010, vsel=00), each one cycle; w=0 for exactly 5 cycles.
REQ-035 CMP vs MOV reg: 101/01 -> loads=1 in the 4th cycle and write never asserted; 110/00 -> loada never asserted and asel=1 in EXEC.
REQ-036 Illegal opcode 111 -> DECODE then WAIT, no enables asserted, err=1 until the next accepted s.
REQ-037 Async reset: reset_n low during GET_B (mid-ADD) -> w=1 and loadb=0 immediately without a clock edge; no write after release.
REQ-038 Back-to-back: s held 1 across two MVN instructions -> exactly one WAIT cycle between them; 2 writes total.
